accum_ctrl: RTL and testbench

- Sequential front end for the 16-bit lab adders (ripple, lookahead or carry-select).
- Holds a 16-bit accumulator, presents `op_a` = accumulator and `op_b` = latched switch operand to an external combinational adder, then captures the sum and carry after a fixed settle delay.
- Each Run press triggers exactly one accumulate, regardless of how long the button is held.
- Sits between board I/O (switches, buttons) and the adder instance; its accumulator drives the LED/hex display.

---
 rtl/accum_pkg.sv | 17 +
 rtl/accum_ctrl_rise_detect.sv | 21 ++
 rtl/accum_ctrl.sv | 126 ++++++++++++
 tb/tb_accum_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types for the accumulator front end: state encoding and word type.
package accum_pkg;

    localparam int ACC_W = 16;
    // Settle counter width; covers SETTLE values 1..15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        CAPT,
        HOLD
    } accum_state_t;

    typedef logic [ACC_W-1:0] word_t;

endpackage

// File: rtl/accum_ctrl_rise_detect.sv
// Rising-edge detector; history flop resets to 1 so a level held through reset never fires.
module rise_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= in_i;
        end
    end

    assign rise_o = in_i & ~prev_q;

endmodule

// File: rtl/accum_ctrl.sv
// Sequencer around an external combinational adder: one accumulate per Run press.
// Optional subtract mode is enabled by defining ACCUM_SUB_EN.
module accum_ctrl
    import accum_pkg::*;
#(
    parameter int WIDTH  = ACC_W,
    parameter int SETTLE = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             Run,
    input  logic [WIDTH-1:0] SW,
    input  logic             Sub,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             cin,
    output logic [WIDTH-1:0] Acc,
    output logic             Carry,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    accum_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             carry_q, carry_d;
    logic             cin_q, cin_d;
    logic             done_q, done_d;
    logic             run_rise;

    rise_detect u_run_rise (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .in_i   (Run),
        .rise_o (run_rise)
    );

`ifndef ACCUM_SUB_EN
    logic unused_sub;
    assign unused_sub = Sub;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        opb_d   = opb_q;
        cin_d   = cin_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // A Run edge takes priority over Clear in the same cycle.
                if (run_rise) begin
                    opb_d   = SW;
                    cin_d   = 1'b0;
`ifdef ACCUM_SUB_EN
                    if (Sub) begin
                        opb_d = ~SW;
                        cin_d = 1'b1;
                    end
`endif
                    cnt_d   = '0;
                    state_d = ADD;
                end else if (Clear) begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                end
            end
            ADD: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                acc_d   = sum_in;
                carry_d = cout_in;
                done_d  = 1'b1;
                state_d = Run ? HOLD : IDLE;
            end
            HOLD: begin
                if (!Run) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            opb_q   <= '0;
            cin_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            opb_q   <= opb_d;
            cin_q   <= cin_d;
            done_q  <= done_d;
        end
    end

    assign op_a  = acc_q;
    assign op_b  = opb_q;
    assign cin   = cin_q;
    assign Acc   = acc_q;
    assign Carry = carry_q;
    assign busy  = (state_q == ADD) || (state_q == CAPT);
    assign done  = done_q;

endmodule

// File: tb/tb_accum_ctrl.sv
// Bench for accum_ctrl: event-level reference model plus directed literal checks.
module tb_accum_ctrl;

    localparam int W      = 16;
    localparam int SETTLE = 2;

    logic         Clk = 1'b0;
    logic         Reset, Clear, Run, Sub, cin, Carry, busy, done, cout_in;
    logic [W-1:0] SW, sum_in, op_a, op_b, Acc;
    logic [W:0]   add_full;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always #5 Clk = ~Clk;

    // External ripple/lookahead adder stand-in.
    assign add_full = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, cin};
    assign sum_in   = add_full[W-1:0];
    assign cout_in  = add_full[W];

    accum_ctrl #(.WIDTH(W), .SETTLE(SETTLE)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Clear   (Clear),
        .Run     (Run),
        .SW      (SW),
        .Sub     (Sub),
        .sum_in  (sum_in),
        .cout_in (cout_in),
        .op_a    (op_a),
        .op_b    (op_b),
        .cin     (cin),
        .Acc     (Acc),
        .Carry   (Carry),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: tracks an in-flight accumulate by its scheduled capture cycle.
    logic [W-1:0] m_acc, m_opb;
    logic         m_carry, m_cin, m_prev, m_pend, m_wrel, m_done;
    int           m_capt, t;

    initial begin
        t = 0; m_capt = 0;
        m_acc = '0; m_opb = '0; m_carry = 0; m_cin = 0;
        m_prev = 1; m_pend = 0; m_wrel = 0; m_done = 0;
        forever begin
            @(posedge Clk);
            if (Reset) begin
                m_acc = '0; m_opb = '0; m_carry = 0; m_cin = 0;
                m_prev = 1; m_pend = 0; m_wrel = 0; m_done = 0;
            end else begin
                m_done = 0;
                if (m_pend) begin
                    if (t == m_capt) begin
                        {m_carry, m_acc} = {1'b0, m_acc} + {1'b0, m_opb} + {{W{1'b0}}, m_cin};
                        m_done = 1;
                        m_pend = 0;
                        m_wrel = Run;
                    end
                end else if (m_wrel) begin
                    if (!Run) m_wrel = 0;
                end else if (Run && !m_prev) begin
                    m_opb = SW;
                    m_cin = 0;
`ifdef ACCUM_SUB_EN
                    if (Sub) begin
                        m_opb = ~SW;
                        m_cin = 1;
                    end
`endif
                    m_pend = 1;
                    m_capt = t + SETTLE + 1;
                end else if (Clear) begin
                    m_acc = '0;
                    m_carry = 0;
                end
                m_prev = Run;
            end
            t++;
            #1;
            chk("acc",   32'(Acc),   32'(m_acc));
            chk("op_a",  32'(op_a),  32'(m_acc));
            chk("op_b",  32'(op_b),  32'(m_opb));
            chk("cin",   32'(cin),   32'(m_cin));
            chk("carry", 32'(Carry), 32'(m_carry));
            chk("busy",  32'(busy),  32'(m_pend));
            chk("done",  32'(done),  32'(m_done));
            if (done) done_cnt++;
        end
    end

    task automatic press(input logic [W-1:0] sw, input logic sub, input int hold);
        SW = sw; Sub = sub; Run = 1;
        repeat (hold) @(negedge Clk);
        Run = 0;
        repeat (SETTLE + 4) @(negedge Clk);
    endtask

    task automatic clear_once();
        Clear = 1;
        @(negedge Clk);
        Clear = 0;
        @(negedge Clk);
    endtask

    initial begin
        int first_done, busy_n;
        Reset = 1; Clear = 0; Run = 0; Sub = 0; SW = '0;
        repeat (3) @(negedge Clk);
        chk("rst_acc",  32'(Acc),  0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        Reset = 0;
        @(negedge Clk);

        // First accumulate: latency and busy width.
        SW = 16'h0005; Run = 1;
        first_done = 0; busy_n = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            if (k == 1) Run = 0;
            if (busy) busy_n++;
            if (done && first_done == 0) first_done = k;
        end
        chk("lat_done",  32'(first_done), 4);
        chk("lat_busy",  32'(busy_n), 3);
        chk("first_acc", 32'(Acc), 32'h0005);
        chk("first_cy",  32'(Carry), 0);

        // Wrap-around.
        clear_once();
        press(16'hFFFF, 0, 1);
        chk("ffff_acc", 32'(Acc), 32'hFFFF);
        press(16'h0001, 0, 1);
        chk("wrap_acc", 32'(Acc), 32'h0000);
        chk("wrap_cy",  32'(Carry), 1);

        // Clear alone wipes both Acc and Carry.
        press(16'hFFF0, 0, 1);
        press(16'h0020, 0, 1);
        chk("pre_clr_acc", 32'(Acc), 32'h0010);
        chk("pre_clr_cy",  32'(Carry), 1);
        clear_once();
        chk("clr_acc", 32'(Acc), 0);
        chk("clr_cy",  32'(Carry), 0);

        // Long hold gives exactly one accumulate.
        done_cnt = 0;
        press(16'h0003, 0, 20);
        chk("hold_done_cnt", 32'(done_cnt), 1);
        chk("hold_acc", 32'(Acc), 32'h0003);
        press(16'h0003, 0, 1);
        chk("repress_acc", 32'(Acc), 32'h0006);

        // Run edge beats Clear.
        SW = 16'h0002; Clear = 1; Run = 1;
        @(negedge Clk);
        Clear = 0; Run = 0;
        repeat (SETTLE + 4) @(negedge Clk);
        chk("run_vs_clr", 32'(Acc), 32'h0008);

        // Reset during ADD aborts.
        done_cnt = 0;
        SW = 16'h0009; Run = 1;
        @(negedge Clk);
        Run = 0; Reset = 1;
        @(negedge Clk);
        Reset = 0;
        repeat (6) @(negedge Clk);
        chk("abort_done", 32'(done_cnt), 0);
        chk("abort_acc",  32'(Acc), 0);
        chk("abort_busy", 32'(busy), 0);

        // Run held through reset does not fire.
        press(16'h0007, 0, 1);
        Run = 1; Reset = 1;
        repeat (2) @(negedge Clk);
        Reset = 0; done_cnt = 0;
        repeat (6) @(negedge Clk);
        chk("held_rst_done", 32'(done_cnt), 0);
        chk("held_rst_acc",  32'(Acc), 0);
        Run = 0;
        @(negedge Clk);
        press(16'h0004, 0, 1);
        chk("after_rel_acc", 32'(Acc), 32'h0004);

        // Sub request.
        clear_once();
        press(16'h0010, 0, 1);
        press(16'h0003, 1, 1);
`ifdef ACCUM_SUB_EN
        chk("sub_acc", 32'(Acc), 32'h000D);
        chk("sub_cy",  32'(Carry), 1);
        chk("sub_opb", 32'(op_b), 32'hFFFC);
        chk("sub_cin", 32'(cin), 1);
`else
        chk("sub_acc", 32'(Acc), 32'h0013);
        chk("sub_cy",  32'(Carry), 0);
        chk("sub_opb", 32'(op_b), 32'h0003);
        chk("sub_cin", 32'(cin), 0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            Reset = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) Run = ~Run;
            Clear = ($urandom_range(0, 7) == 0);
            Sub   = 1'($urandom_range(0, 1));
            SW    = 16'($urandom);
            @(negedge Clk);
        end
        Reset = 0; Run = 0; Clear = 0;
        repeat (SETTLE + 4) @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
